wc_stream: RTL and testbench

Parametrised streaming 1-D Winograd-class convolution engine F(M,R). It succeeds the fixed-coefficient F(3,5) WC block and adds:
- runtime-loadable filter coefficients;
- a valid/ready handshake with backpressure;
- a stream mode that keeps the R-1 sample overlap between tiles;
- saturating outputs with per-result overflow flags.

It sits between the line/tile buffer and the accumulation stage of the convolution datapath.

---
 rtl/wc_stream_if.sv | 34 +++
 rtl/wc_stream.sv | 114 +++++++++++
 tb/tb_wc_stream.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wc_stream_if.sv
// Handshake and configuration bundle for the wc_stream convolution engine.
// The master side (line/tile buffer, config host, accumulator) drives tiles,
// coefficients and out_ready; the slave side is the engine itself.
interface wc_stream_if #(
  parameter int DW = 10,
  parameter int CW = 10,
  parameter int OW = 10,
  parameter int M  = 3,
  parameter int R  = 5
);
  logic                   mode;
  logic                   cfg_we;
  logic [$clog2(R)-1:0]   cfg_addr;
  logic [CW-1:0]          cfg_data;
  logic                   cfg_busy;
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_first;
  logic [(M+R-1)*DW-1:0]  in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [M*OW-1:0]        out_data;
  logic [M-1:0]           out_sat;

  modport master (
    output mode, cfg_we, cfg_addr, cfg_data, in_valid, in_first, in_data, out_ready,
    input  cfg_busy, in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  mode, cfg_we, cfg_addr, cfg_data, in_valid, in_first, in_data, out_ready,
    output cfg_busy, in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/wc_stream.sv
// Streaming 1-D F(M,R) correlation engine with loadable taps, tile/stream
// windowing, saturating outputs and a freeze-on-stall result pipeline.
// Results are computed exactly at accept time and then carried through
// LAT register stages so the output appears LAT edges after the accept.
module wc_stream #(
  parameter int DW  = 10,
  parameter int CW  = 10,
  parameter int OW  = 10,
  parameter int M   = 3,
  parameter int R   = 5,
  parameter int LAT = 4
) (
  input logic       clk,
  input logic       rst,
  wc_stream_if.slave s
);
  localparam int NW = M + R - 1;                 // window length
  localparam int HN = R - 1;                     // overlap kept between stream tiles
  localparam int AW = DW + CW + $clog2(R) + 1;   // exact accumulator width

  localparam logic signed [AW-1:0] SMAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN = ~SMAX;

  logic signed [CW-1:0] g [R];
  logic signed [DW-1:0] h [HN];
  logic signed [DW-1:0] w [NW];
  logic signed [AW-1:0] acc;
  logic [M*OW-1:0]      y_data;
  logic [M-1:0]         y_sat;

  logic [LAT:0]         pv;
  logic [M*OW-1:0]      pd [LAT+1];
  logic [M-1:0]         ps [LAT+1];

  logic stall;
  logic accept;
  logic cfg_ok;

  assign stall       = pv[LAT] & ~s.out_ready;
  assign s.in_ready  = ~stall;
  assign accept      = s.in_valid & s.in_ready;
  assign s.out_valid = pv[LAT];
  assign s.out_data  = pd[LAT];
  assign s.out_sat   = ps[LAT];
  assign s.cfg_busy  = |pv;
  assign cfg_ok      = s.cfg_we & ~s.cfg_busy & ~s.in_valid & (int'(s.cfg_addr) < R);

  // Window: new samples always sit in the low slices; in stream mode the
  // leading R-1 slots come from history (or zero at the start of a row).
  always_comb begin
    // NOTE: every element gets its tile-mode value first, so no path leaves w unassigned and no latch is inferred.
    for (int j = 0; j < NW; j++) begin
      w[j] = s.in_data[(NW-1-j)*DW +: DW];
      if (s.mode && j < HN) w[j] = s.in_first ? '0 : h[j];
    end
  end

  // Direct correlation per result, then clip to the OW range.
  always_comb begin
    y_data = '0;
    y_sat  = '0;
    acc    = '0;
    for (int i = 0; i < M; i++) begin
      acc = '0;
      for (int k = 0; k < R; k++) begin
        acc = acc + AW'(w[i+k]) * AW'(g[k]);
      end
      if (acc > SMAX) begin
        y_data[(M-1-i)*OW +: OW] = SMAX[OW-1:0];
        y_sat[M-1-i]             = 1'b1;
      end else if (acc < SMIN) begin
        y_data[(M-1-i)*OW +: OW] = SMIN[OW-1:0];
        y_sat[M-1-i]             = 1'b1;
      end else begin
        y_data[(M-1-i)*OW +: OW] = acc[OW-1:0];
      end
    end
  end

  // Coefficient writes (only when idle and no tile offered) and stream history.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every block samples pre-edge values.
    if (rst) begin
      for (int k = 0; k < R; k++) g[k] <= '0;
      for (int j = 0; j < HN; j++) h[j] <= '0;
    end else begin
      if (cfg_ok) g[s.cfg_addr] <= s.cfg_data;
      if (accept && s.mode) begin
        for (int j = 0; j < HN; j++) h[j] <= w[M+j];
      end
    end
  end

  // Result pipeline: shifts every cycle unless the output is stalled.
  always_ff @(posedge clk) begin
    // NOTE: data stages are reset as well as valid bits, because out_data has a defined reset value and shifts from upstream stages.
    if (rst) begin
      pv <= '0;
      for (int i = 0; i <= LAT; i++) begin
        pd[i] <= '0;
        ps[i] <= '0;
      end
    end else if (!stall) begin
      pv[0] <= accept;
      pd[0] <= y_data;
      ps[0] <= y_sat;
      for (int i = 1; i <= LAT; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
        ps[i] <= ps[i-1];
      end
    end
  end
endmodule

// File: tb/tb_wc_stream.sv
// Directed bench for wc_stream: tiles are driven in one linear sequence,
// their expected results queued at accept, and a monitor compares each
// output transfer (data, saturation flags, latency) against the queue head.
module tb_wc_stream;
  localparam int DW  = 10;
  localparam int CW  = 10;
  localparam int OW  = 10;
  localparam int M   = 3;
  localparam int R   = 5;
  localparam int LAT = 4;
  localparam int NW  = M + R - 1;

  typedef struct {
    logic [M*OW-1:0] data;
    logic [M-1:0]    sat;
    int              acc_cyc;
    bit              chk_lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wc_stream_if #(.DW(DW), .CW(CW), .OW(OW), .M(M), .R(R)) bus ();

  wc_stream #(.DW(DW), .CW(CW), .OW(OW), .M(M), .R(R), .LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .s   (bus.slave)
  );

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   gm [R];            // coefficients the bench believes are loaded

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NW*DW-1:0] pack_x(input int x[NW]);
    logic [NW*DW-1:0] r;
    r = '0;
    for (int j = 0; j < NW; j++) r[(NW-1-j)*DW +: DW] = DW'(x[j]);
    return r;
  endfunction

  function automatic logic [M*OW-1:0] pack_y(input int y[M]);
    logic [M*OW-1:0] r;
    r = '0;
    for (int i = 0; i < M; i++) r[(M-1-i)*OW +: OW] = OW'(y[i]);
    return r;
  endfunction

  // Tile-mode reference: direct correlation with gm, clipped to 10 bits.
  function automatic void model(input int x[NW], output logic [M*OW-1:0] d, output logic [M-1:0] sat);
    int a;
    d   = '0;
    sat = '0;
    for (int i = 0; i < M; i++) begin
      a = 0;
      for (int k = 0; k < R; k++) a += gm[k] * x[i+k];
      if (a > 511) begin a = 511; sat[M-1-i] = 1'b1; end
      if (a < -512) begin a = -512; sat[M-1-i] = 1'b1; end
      d[(M-1-i)*OW +: OW] = OW'(a);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int addr, input int data);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 3'(addr);
    bus.cfg_data = CW'(data);
    step();
    bus.cfg_we   = 1'b0;
  endtask

  task automatic load_g(input int gv[R]);
    for (int k = 0; k < R; k++) begin
      cfg_write(k, gv[k]);
      gm[k] = gv[k];
    end
  endtask

  // Offer one tile and wait (bounded) for its accept edge.
  task automatic send_tile(input bit md, input bit first, input logic [NW*DW-1:0] din,
                           input logic [M*OW-1:0] ed, input logic [M-1:0] es,
                           input bit chk_lat, input bit push);
    bit accepted;
    accepted     = 1'b0;
    bus.mode     = md;
    bus.in_first = first;
    bus.in_data  = din;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 200 && !accepted; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        accepted = 1'b1;
        if (push) sb.push_back('{ed, es, cyc + 1, chk_lat});
      end
      step();
    end
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    check("accept_timeout", 64'(accepted), 64'd1);
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int t = 0; t < 200 && !idle; t++) begin
      @(negedge clk);
      idle = (sb.size() == 0) && !bus.cfg_busy;
    end
    check("drain", 64'(idle), 64'd1);
    step();
  endtask

  // Scoreboard: pop and compare on every output transfer.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 64'(bus.out_valid), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("out_data", 64'(bus.out_data), 64'(mon_e.data));
        check("out_sat", 64'(bus.out_sat), 64'(mon_e.sat));
        if (mon_e.chk_lat) check("latency", 64'(cyc - mon_e.acc_cyc), 64'(LAT));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [M*OW-1:0] ed;
    logic [M-1:0]    es;
    int              x [NW];
    int              x6 [NW];
    bit              seen_out;

    rst          = 1'b1;
    bus.mode     = 1'b0;
    bus.cfg_we   = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_data = '0;
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_data  = '0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < R; k++) gm[k] = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_out_sat", 64'(bus.out_sat), 64'd0);
    check("rst_cfg_busy", 64'(bus.cfg_busy), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    step();

    // Pass-through
    load_g('{1, 0, 0, 0, 0});
    send_tile(1'b0, 1'b0, pack_x('{2, -10, 3, 4, -13, -18, -16}), pack_y('{2, -10, 3}), 3'b000, 1'b1, 1'b1);
    wait_idle();

    // Box filter, two tiles back to back
    load_g('{1, 1, 1, 1, 1});
    send_tile(1'b0, 1'b0, pack_x('{2, -10, 3, 4, -13, -18, -16}), pack_y('{-14, -34, -40}), 3'b000, 1'b1, 1'b1);
    send_tile(1'b0, 1'b0, pack_x('{-19, -6, 3, -9, -12, 11, -4}), pack_y('{-43, -13, -11}), 3'b000, 1'b1, 1'b1);
    wait_idle();

    // Saturation both directions
    load_g('{511, 511, 511, 511, 511});
    send_tile(1'b0, 1'b0, pack_x('{511, 511, 511, 511, 511, 511, 511}), pack_y('{511, 511, 511}), 3'b111, 1'b1, 1'b1);
    send_tile(1'b0, 1'b0, pack_x('{-512, -512, -512, -512, -512, -512, -512}), pack_y('{-512, -512, -512}), 3'b111, 1'b1, 1'b1);
    wait_idle();

    // Stream overlap; leading slots carry junk that must be ignored, and a
    // tile-mode tile in the middle must leave history alone.
    load_g('{1, 2, 3, 4, 5});
    send_tile(1'b1, 1'b1, pack_x('{511, -512, 77, -3, 1, 2, 3}), pack_y('{5, 14, 26}), 3'b000, 1'b1, 1'b1);
    send_tile(1'b1, 1'b0, pack_x('{9, 9, 9, 9, 4, 5, 6}), pack_y('{40, 55, 70}), 3'b000, 1'b1, 1'b1);
    send_tile(1'b0, 1'b1, pack_x('{0, 0, 0, 0, 0, 0, 0}), pack_y('{0, 0, 0}), 3'b000, 1'b1, 1'b1);
    send_tile(1'b1, 1'b0, pack_x('{1, 1, 1, 1, 7, 8, 9}), pack_y('{85, 100, 115}), 3'b000, 1'b1, 1'b1);
    // New row: window is {0,0,0,0,4,5,6}
    send_tile(1'b1, 1'b1, pack_x('{9, 9, 9, 9, 4, 5, 6}), pack_y('{20, 41, 62}), 3'b000, 1'b1, 1'b1);
    wait_idle();

    // Backpressure: five tiles fill the pipeline, the sixth must wait.
    load_g('{1, 1, 1, 1, 1});
    bus.out_ready = 1'b0;
    for (int t = 0; t < 5; t++) begin
      for (int j = 0; j < NW; j++) x[j] = int'($urandom_range(0, 1023)) - 512;
      model(x, ed, es);
      send_tile(1'b0, 1'b0, pack_x(x), ed, es, 1'b0, 1'b1);
    end
    check("fill_back_to_back", 64'(sb[4].acc_cyc - sb[0].acc_cyc), 64'd4);
    for (int j = 0; j < NW; j++) x6[j] = int'($urandom_range(0, 1023)) - 512;
    bus.mode     = 1'b0;
    bus.in_data  = pack_x(x6);
    bus.in_valid = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      check("stall_in_ready", 64'(bus.in_ready), 64'd0);
      check("stall_out_valid", 64'(bus.out_valid), 64'd1);
      check("stall_hold_data", 64'(bus.out_data), 64'(sb[0].data));
      step();
    end
    bus.out_ready = 1'b1;
    model(x6, ed, es);
    send_tile(1'b0, 1'b0, pack_x(x6), ed, es, 1'b0, 1'b1);
    wait_idle();

    // Config guard: write while busy, then write in the same cycle as an accept.
    x = '{2, -10, 3, 4, -13, -18, -16};
    send_tile(1'b0, 1'b0, pack_x(x), pack_y('{-14, -34, -40}), 3'b000, 1'b1, 1'b1);
    check("busy_after_accept", 64'(bus.cfg_busy), 64'd1);
    cfg_write(0, 7);
    wait_idle();
    send_tile(1'b0, 1'b0, pack_x(x), pack_y('{-14, -34, -40}), 3'b000, 1'b1, 1'b1);
    wait_idle();
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 3'd0;
    bus.cfg_data = 10'd7;
    send_tile(1'b0, 1'b0, pack_x(x), pack_y('{-14, -34, -40}), 3'b000, 1'b1, 1'b1);
    bus.cfg_we   = 1'b0;
    wait_idle();
    send_tile(1'b0, 1'b0, pack_x(x), pack_y('{-14, -34, -40}), 3'b000, 1'b1, 1'b1);
    wait_idle();

    // Reset with three tiles in flight: nothing may come out.
    for (int t = 0; t < 3; t++) send_tile(1'b0, 1'b0, pack_x(x), '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    check("busy_inflight", 64'(bus.cfg_busy), 64'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < R; k++) gm[k] = 0;
    seen_out = 1'b0;
    for (int t = 0; t < LAT + 4; t++) begin
      @(negedge clk);
      if (bus.out_valid) seen_out = 1'b1;
    end
    check("rst_flush_no_out", 64'(seen_out), 64'd0);
    check("rst_flush_busy", 64'(bus.cfg_busy), 64'd0);
    step();
    // Coefficients cleared by reset, so any tile yields zeros.
    send_tile(1'b0, 1'b0, pack_x('{100, 100, 100, 100, 100, 100, 100}), pack_y('{0, 0, 0}), 3'b000, 1'b1, 1'b1);
    wait_idle();
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
